// File: rtl/reset_sequencer.sv
// Reset release sequencer for the 25.175 MHz domain: lock filter, staged periph/CPU release, cause capture.
// Optional watchdog timeout path is built only when RSTSEQ_WATCHDOG_EN is defined.
module reset_sequencer #(
    parameter int LOCK_CYCLES  = 16,
    parameter int CPU_DELAY    = 16,
    parameter int PULSE_CYCLES = 4,
    parameter int WDT_BITS     = 25,
    parameter int WDT_TIMEOUT  = 25175000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic       lock,
    input  logic       sw_rst_req,
    input  logic       wdt_en,
    input  logic       wdt_kick,
    output logic       periph_rst,
    output logic       cpu_rst,
    output logic [1:0] rst_cause,
    output logic       running
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        PERIPH    = 2'd1,
        RUN       = 2'd2,
        PULSE     = 2'd3
    } state_t;

    localparam logic [7:0] LOCK_LAST  = 8'(LOCK_CYCLES - 1);
    localparam logic [7:0] CPU_LAST   = 8'(CPU_DELAY - 1);
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR  = 2'd0;
    localparam logic [1:0] CAUSE_LOCK = 2'd1;
    localparam logic [1:0] CAUSE_SW   = 2'd2;
    localparam logic [1:0] CAUSE_WDT  = 2'd3;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [1:0] cause_nxt;
    logic       wdt_timeout;

`ifdef RSTSEQ_WATCHDOG_EN
    localparam logic [WDT_BITS-1:0] WDT_RELOAD = WDT_BITS'(WDT_TIMEOUT);

    logic [WDT_BITS-1:0] wdt_cnt, wdt_nxt;

    // A kick on the zero cycle reloads instead of timing out.
    always_comb begin
        wdt_timeout = (state == RUN) && wdt_en && !wdt_kick && (wdt_cnt == '0);
    end

    // Counter only runs while staying in RUN with the watchdog enabled; otherwise it sits at reload.
    always_comb begin
        wdt_nxt = WDT_RELOAD;
        if ((state == RUN) && (state_nxt == RUN) && wdt_en && !wdt_kick) begin
            wdt_nxt = wdt_cnt - WDT_BITS'(1);
        end
    end

    always_ff @(posedge clk25) begin
        if (rst) begin
            wdt_cnt <= WDT_RELOAD;
        end else begin
            wdt_cnt <= wdt_nxt;
        end
    end
`else
    logic unused_wdt;
    assign unused_wdt  = wdt_en ^ wdt_kick ^ (WDT_TIMEOUT == 0) ^ (WDT_BITS == 0);
    assign wdt_timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt + 8'd1;
        cause_nxt = rst_cause;

        if ((state != WAIT_LOCK) && !lock) begin
            state_nxt = WAIT_LOCK;
            cause_nxt = CAUSE_LOCK;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (!lock) begin
                        cnt_nxt = 8'd0;
                    end else if (cnt == LOCK_LAST) begin
                        state_nxt = PERIPH;
                    end
                end
                PERIPH: begin
                    if (cnt == CPU_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    cnt_nxt = 8'd0;
                    if (wdt_timeout) begin
                        state_nxt = PULSE;
                        cause_nxt = CAUSE_WDT;
                    end else if (sw_rst_req) begin
                        state_nxt = PULSE;
                        cause_nxt = CAUSE_SW;
                    end
                end
                PULSE: begin
                    if (cnt == PULSE_LAST) begin
                        state_nxt = PERIPH;
                    end
                end
                default: state_nxt = WAIT_LOCK;
            endcase
        end

        if (state_nxt != state) begin
            cnt_nxt = 8'd0;
        end
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk25) begin
        if (rst) begin
            state      <= WAIT_LOCK;
            cnt        <= 8'd0;
            periph_rst <= 1'b1;
            cpu_rst    <= 1'b1;
            rst_cause  <= CAUSE_POR;
            running    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            periph_rst <= (state_nxt == WAIT_LOCK) || (state_nxt == PULSE);
            cpu_rst    <= (state_nxt != RUN);
            rst_cause  <= cause_nxt;
            running    <= (state_nxt == RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed release/reset scenarios followed by random traffic,
// all compared each cycle against a phase/elapsed-time model of the sequencing rules.
module tb_reset_sequencer;

    localparam int LOCK_N  = 16;
    localparam int CPU_N   = 16;
    localparam int PULSE_N = 4;
    localparam int WDT_T   = 100;

    localparam int M_WAIT   = 0;
    localparam int M_PERIPH = 1;
    localparam int M_RUN    = 2;
    localparam int M_PULSE  = 3;

`ifdef RSTSEQ_WATCHDOG_EN
    localparam bit HAS_WDT = 1'b1;
`else
    localparam bit HAS_WDT = 1'b0;
`endif

    logic       clk25 = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       sw_rst_req = 1'b0;
    logic       wdt_en = 1'b0;
    logic       wdt_kick = 1'b0;
    logic       periph_rst;
    logic       cpu_rst;
    logic [1:0] rst_cause;
    logic       running;

    int checks = 0;
    int failures = 0;

    int m_phase = M_WAIT;
    int m_n = 0;
    int m_cause = 0;
    int m_wdt = WDT_T;

    int pfall, cfall, rrise, dropped;

    reset_sequencer #(
        .LOCK_CYCLES (LOCK_N),
        .CPU_DELAY   (CPU_N),
        .PULSE_CYCLES(PULSE_N),
        .WDT_BITS    (25),
        .WDT_TIMEOUT (WDT_T)
    ) dut (
        .clk25     (clk25),
        .rst       (rst),
        .lock      (lock),
        .sw_rst_req(sw_rst_req),
        .wdt_en    (wdt_en),
        .wdt_kick  (wdt_kick),
        .periph_rst(periph_rst),
        .cpu_rst   (cpu_rst),
        .rst_cause (rst_cause),
        .running   (running)
    );

    always #5 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: which phase we are in and how many cycles have elapsed in it.
    task automatic model_update(input logic r, input logic l, input logic s,
                                input logic e, input logic k);
        bit expired;
        expired = 1'b0;
        if (r) begin
            m_phase = M_WAIT; m_n = 0; m_cause = 0; m_wdt = WDT_T;
            return;
        end
        if (m_phase != M_WAIT && !l) begin
            m_phase = M_WAIT; m_n = 0; m_cause = 1; m_wdt = WDT_T;
            return;
        end
        case (m_phase)
            M_WAIT: begin
                m_n = l ? m_n + 1 : 0;
                if (m_n == LOCK_N) begin m_phase = M_PERIPH; m_n = 0; end
            end
            M_PERIPH: begin
                m_n++;
                if (m_n == CPU_N) begin m_phase = M_RUN; m_n = 0; m_wdt = WDT_T; end
            end
            M_PULSE: begin
                m_n++;
                if (m_n == PULSE_N) begin m_phase = M_PERIPH; m_n = 0; end
            end
            default: begin
                if (HAS_WDT && e) begin
                    if (k) m_wdt = WDT_T;
                    else if (m_wdt == 0) expired = 1'b1;
                    else m_wdt--;
                end else begin
                    m_wdt = WDT_T;
                end
                if (expired) begin
                    m_phase = M_PULSE; m_n = 0; m_cause = 3;
                end else if (s) begin
                    m_phase = M_PULSE; m_n = 0; m_cause = 2;
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge clk25);
        model_update(rst, lock, sw_rst_req, wdt_en, wdt_kick);
        #1;
        chk("periph_rst", 32'(periph_rst), int'(m_phase == M_WAIT || m_phase == M_PULSE));
        chk("cpu_rst", 32'(cpu_rst), int'(m_phase != M_RUN));
        chk("running", 32'(running), int'(m_phase == M_RUN));
        chk("rst_cause", 32'(rst_cause), m_cause);
    endtask

    task automatic measure_release(input int edges);
        pfall = -1; cfall = -1; rrise = -1;
        for (int e = 1; e <= edges; e++) begin
            step();
            if (pfall < 0 && periph_rst === 1'b0) pfall = e;
            if (cfall < 0 && cpu_rst === 1'b0) cfall = e;
            if (rrise < 0 && running === 1'b1) rrise = e;
        end
    endtask

    initial begin
        // Power-on with constant lock
        rst = 1'b1; lock = 1'b1;
        repeat (4) step();
        chk("por_periph", 32'(periph_rst), 1);
        chk("por_cause", 32'(rst_cause), 0);
        rst = 1'b0;
        measure_release(40);
        chk("por_periph_fall_edge", pfall, 16);
        chk("por_cpu_fall_edge", cfall, 32);
        chk("por_running_edge", rrise, 32);
        chk("por_cause_after", 32'(rst_cause), 0);

        // Lock glitch while filtering
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (10) step();
        lock = 1'b0;
        step();
        lock = 1'b1;
        measure_release(40);
        chk("glitch_periph_fall_edge", pfall, 16);
        chk("glitch_cpu_fall_edge", cfall, 32);
        chk("glitch_cause", 32'(rst_cause), 0);

        // Software reset pulse from RUN
        sw_rst_req = 1'b1;
        step();
        sw_rst_req = 1'b0;
        chk("sw_periph_high", 32'(periph_rst), 1);
        chk("sw_cpu_high", 32'(cpu_rst), 1);
        chk("sw_cause", 32'(rst_cause), 2);
        measure_release(30);
        chk("sw_periph_fall_edge", pfall, 4);
        chk("sw_cpu_fall_edge", cfall, 20);

        // Lock loss in RUN, then full relock
        lock = 1'b0;
        step();
        lock = 1'b1;
        chk("loss_cpu_high", 32'(cpu_rst), 1);
        chk("loss_cause", 32'(rst_cause), 1);
        measure_release(40);
        chk("loss_periph_fall_edge", pfall, 16);
        chk("loss_cpu_fall_edge", cfall, 32);
        chk("loss_cause_kept", 32'(rst_cause), 1);

        // Lock loss and software request together: lock loss wins
        lock = 1'b0; sw_rst_req = 1'b1;
        step();
        lock = 1'b1; sw_rst_req = 1'b0;
        chk("simul_cause", 32'(rst_cause), 1);
        chk("simul_periph", 32'(periph_rst), 1);
        repeat (20) step();
        chk("mid_periph_low", 32'(periph_rst), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_periph", 32'(periph_rst), 1);
        chk("midrst_cpu", 32'(cpu_rst), 1);
        chk("midrst_running", 32'(running), 0);
        chk("midrst_cause", 32'(rst_cause), 0);
        measure_release(32);
        chk("midrst_cpu_fall_edge", cfall, 32);

        // Watchdog: just entered RUN on the last edge
        wdt_en = 1'b1;
        dropped = -1;
        for (int e = 1; e <= 150; e++) begin
            step();
            if (dropped < 0 && running === 1'b0) dropped = e;
        end
        if (HAS_WDT) begin
            chk("wdt_timeout_edge", dropped, 101);
            chk("wdt_cause", 32'(rst_cause), 3);
        end else begin
            chk("nowdt_no_drop", dropped, -1);
            chk("nowdt_cause", 32'(rst_cause), 0);
        end
        repeat (20) step();
        chk("kick_start_running", 32'(running), 1);
        dropped = 0;
        for (int i = 0; i < 1000; i++) begin
            wdt_kick = (i % 50 == 0);
            step();
            if (running !== 1'b1) dropped++;
        end
        wdt_kick = 1'b0;
        wdt_en = 1'b0;
        chk("kick_no_reset", dropped, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 499) == 0);
            lock       = ($urandom_range(0, 199) != 0);
            sw_rst_req = ($urandom_range(0, 99) < 2);
            wdt_kick   = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 99) == 0) wdt_en = ~wdt_en;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
